// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and sizes for the 8-requester round-robin mux arbiter.
// Holds the requester count, the select width and the arbiter state encoding.
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr, searching upward mod 8.
// The search rotates the requests, priority-encodes the lowest set bit, then adds ptr back.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]   off;

    // Doubling the vector makes the rotate a plain part-select: req_rot[k] = req[(ptr+k) mod 8].
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = SEL_W'(k);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule : rr_pick

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that drives the select of a shared 8:1 bit mux, with registered grant outputs.
// Define MUX_ARB_BURST_LIMIT_EN to cap each tenure at MAX_BURST cycles; otherwise an owner holds until it drops req.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] S,
    output logic             gnt_valid
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must lie in 1..255");
    end

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             release_now;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    logic [7:0] cnt_q, cnt_d;

    // A still-requesting owner is forced off on its last allowed cycle.
    assign release_now = !req[sel_q] || (cnt_q == BURST_LAST);
`else
    assign release_now = !req[sel_q];
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
`ifdef MUX_ARB_BURST_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = N_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    vld_d   = 1'b1;
                    state_d = GRANT;
`ifdef MUX_ARB_BURST_LIMIT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    gnt_d = '0;
                    vld_d = 1'b0;
                end
            end
            GRANT: begin
                // Only the owner's request matters here; other requesters cannot preempt.
                if (release_now) begin
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                    state_d = IDLE;
                end else begin
`ifdef MUX_ARB_BURST_LIMIT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
`ifdef MUX_ARB_BURST_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign S         = sel_q;
    assign gnt_valid = vld_q;

endmodule : mux8_rr_arbiter
